// File: rtl/btn_conditioner_if.sv
// Button bundle between the board pins and core.
// The board/bench side uses the master modport. The conditioner uses the slave modport.
interface btn_conditioner_if #(
    parameter int NBTN = 5
);
    logic [NBTN-1:0] btn_raw;   // raw pin levels, 1 = pressed
    logic [NBTN-1:0] btn;       // debounced levels
    logic [NBTN-1:0] btn_dn;    // press / repeat strobes
    logic [NBTN-1:0] btn_up;    // release strobes

    modport master (
        output btn_raw,
        input  btn,
        input  btn_dn,
        input  btn_up
    );

    modport slave (
        input  btn_raw,
        output btn,
        output btn_dn,
        output btn_up
    );
endinterface

// File: rtl/btn_conditioner.sv
// btn_conditioner: synchronises, debounces and edge-detects NBTN push-buttons.
// Each button has its own channel, made of three parts:
//   - a 2-flop synchroniser,
//   - a debounce counter,
//   - a small IDLE/PRESS(/HOLD) state machine that drives the registered
//     press and release strobes.
// Optional feature: define BTN_REPEAT_EN to add auto-repeat btn_dn strobes
// while a button is held. The repeat counter and the HOLD state exist only
// in that build.
module btn_conditioner #(
    parameter int NBTN       = 5,
    parameter int DB_CYCLES  = 400000,
    parameter int RPT_DELAY  = 20000000,
    parameter int RPT_PERIOD = 4000000
) (
    input  logic             clk,
    input  logic             rst,   // asynchronous, active-low
    btn_conditioner_if.slave bus
);
    localparam int DBW = $clog2(DB_CYCLES + 1);

`ifdef BTN_REPEAT_EN
    localparam int RPT_MAX = (RPT_DELAY > RPT_PERIOD) ? RPT_DELAY : RPT_PERIOD;
    localparam int RPW     = $clog2(RPT_MAX + 1);
    typedef enum logic [1:0] {IDLE, PRESS, HOLD} state_t;
`else
    typedef enum logic [0:0] {IDLE, PRESS} state_t;
`endif

    // Zero-length windows would make the compare-and-clear counters meaningless.
    if (DB_CYCLES < 1 || RPT_DELAY < 1 || RPT_PERIOD < 1) begin : g_param_check
        $error("btn_conditioner: DB_CYCLES, RPT_DELAY and RPT_PERIOD must all be >= 1");
    end

    logic [NBTN-1:0] btn_w;
    logic [NBTN-1:0] btn_dn_w;
    logic [NBTN-1:0] btn_up_w;

    for (genvar gi = 0; gi < NBTN; gi++) begin : g_chan
        logic           sync1_q;
        logic           s_q;
        logic           btn_q;
        logic           dn_q;
        logic           up_q;
        logic [DBW-1:0] dbc_q;
        logic           mismatch;
        logic           accept;
        state_t         state_q;
`ifdef BTN_REPEAT_EN
        logic [RPW-1:0] rpc_q;
`endif

        // The synchronised level differs from the accepted one.
        // accept is high on the cycle that difference becomes the new level.
        assign mismatch = (s_q != btn_q);
        assign accept   = mismatch && (dbc_q == DBW'(DB_CYCLES - 1));

        // Two-flop synchroniser for the asynchronous pin.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                sync1_q <= 1'b0;
                s_q     <= 1'b0;
            end else begin
                sync1_q <= bus.btn_raw[gi];
                s_q     <= sync1_q;
            end
        end

        // Debounce: count consecutive mismatching cycles.
        // Any cycle that agrees with the accepted level restarts the count.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                btn_q <= 1'b0;
                dbc_q <= '0;
            end else if (!mismatch) begin
                dbc_q <= '0;
            end else if (accept) begin
                btn_q <= s_q;
                dbc_q <= '0;
            end else begin
                dbc_q <= dbc_q + DBW'(1);
            end
        end

        // Press/hold state machine.
        // Its strobes are registered, so they line up with the btn_q change.
        // An accepted fall always wins over a repeat due in the same cycle.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                state_q <= IDLE;
                dn_q    <= 1'b0;
                up_q    <= 1'b0;
`ifdef BTN_REPEAT_EN
                rpc_q   <= '0;
`endif
            end else begin
                dn_q <= 1'b0;
                up_q <= 1'b0;
                case (state_q)
                    IDLE: begin
                        if (accept && s_q) begin
                            state_q <= PRESS;
                            dn_q    <= 1'b1;
`ifdef BTN_REPEAT_EN
                            rpc_q   <= '0;
`endif
                        end
                    end
                    PRESS: begin
                        if (accept && !s_q) begin
                            state_q <= IDLE;
                            up_q    <= 1'b1;
                        end
`ifdef BTN_REPEAT_EN
                        else if (rpc_q == RPW'(RPT_DELAY - 1)) begin
                            state_q <= HOLD;
                            dn_q    <= 1'b1;
                            rpc_q   <= '0;
                        end else begin
                            rpc_q   <= rpc_q + RPW'(1);
                        end
`endif
                    end
`ifdef BTN_REPEAT_EN
                    HOLD: begin
                        if (accept && !s_q) begin
                            state_q <= IDLE;
                            up_q    <= 1'b1;
                        end else if (rpc_q == RPW'(RPT_PERIOD - 1)) begin
                            dn_q    <= 1'b1;
                            rpc_q   <= '0;
                        end else begin
                            rpc_q   <= rpc_q + RPW'(1);
                        end
                    end
`endif
                    default: state_q <= IDLE;
                endcase
            end
        end

        assign btn_w[gi]    = btn_q;
        assign btn_dn_w[gi] = dn_q;
        assign btn_up_w[gi] = up_q;
    end

    assign bus.btn    = btn_w;
    assign bus.btn_dn = btn_dn_w;
    assign bus.btn_up = btn_up_w;
endmodule
